// File: rtl/plru_victim_ctrl.sv
// plru_victim_ctrl
//   Request sequencer in front of one pseudo-LRU state array. A hit promotes
//   the hitting way. A miss reads the PLRU way and picks a victim, preferring
//   the lowest invalid way. It then runs the writeback and fill handshakes as
//   needed, and finally promotes the victim.
//   Optional build macro: PLRU_VICTIM_STATS_EN adds saturating 32-bit
//   hit / miss / writeback counters as extra outputs.
module plru_victim_ctrl #(
  parameter int S_INDEX = 3,
  parameter int S_ASSOC = 8,
  parameter int S_WIDTH = $clog2(S_ASSOC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [S_INDEX-1:0] req_index,
  input  logic               req_hit,
  input  logic [S_ASSOC-1:0] req_hit_way,
  input  logic [S_ASSOC-1:0] set_valid,
  input  logic [S_ASSOC-1:0] set_dirty,
  output logic               plru_read,
  output logic               plru_load,
  output logic [S_INDEX-1:0] plru_index,
  output logic [S_ASSOC-1:0] plru_tag_hit,
  input  logic [S_WIDTH-1:0] plru_way,
  input  logic               plru_valid,
  output logic               wb_req,
  input  logic               wb_ack,
  output logic               fill_req,
  input  logic               fill_ack,
  output logic               resp_valid,
  output logic [S_WIDTH-1:0] resp_way
`ifdef PLRU_VICTIM_STATS_EN
  ,
  output logic [31:0]        stat_hits,
  output logic [31:0]        stat_misses,
  output logic [31:0]        stat_wbs
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    HIT_UPD,
    LRU_RD,
    LRU_WAIT,
    WB,
    FILL,
    MISS_UPD
  } state_t;

  state_t             state;
  logic [S_ASSOC-1:0] valid_q;
  logic [S_ASSOC-1:0] dirty_q;
  logic [S_WIDTH-1:0] victim;
  logic [S_WIDTH-1:0] victim_nx;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [S_WIDTH-1:0] lowest_set(input logic [S_ASSOC-1:0] v);
    // NOTE: assign a default before the loop so every path drives a value; otherwise a combinational caller infers a latch.
    lowest_set = '0;
    for (int i = S_ASSOC - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = S_WIDTH'(i);
    end
  endfunction

  // Victim choice: an invalid way first, then the PLRU way if the array's output is valid, else way 0.
  always_comb begin
    victim_nx = '0;
    if (!(&valid_q))  victim_nx = lowest_set(~valid_q);
    else if (plru_valid) victim_nx = plru_way;
  end

  // Main sequencer. Outputs are registered and take the values for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      plru_read    <= 1'b0;
      plru_load    <= 1'b0;
      plru_index   <= '0;
      plru_tag_hit <= '0;
      wb_req       <= 1'b0;
      fill_req     <= 1'b0;
      resp_valid   <= 1'b0;
      resp_way     <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      victim       <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every register sees pre-edge values regardless of statement order.
      plru_read  <= 1'b0;
      plru_load  <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            plru_index <= req_index;
            valid_q    <= set_valid;
            dirty_q    <= set_dirty;
            if (req_hit) begin
              state        <= HIT_UPD;
              plru_load    <= 1'b1;
              plru_tag_hit <= req_hit_way;
              resp_valid   <= 1'b1;
              resp_way     <= lowest_set(req_hit_way);
            end else begin
              state     <= LRU_RD;
              plru_read <= 1'b1;
            end
          end
        end
        HIT_UPD: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        LRU_RD: begin
          state <= LRU_WAIT;
        end
        LRU_WAIT: begin
          victim <= victim_nx;
          if (valid_q[victim_nx] && dirty_q[victim_nx]) begin
            state  <= WB;
            wb_req <= 1'b1;
          end else begin
            state    <= FILL;
            fill_req <= 1'b1;
          end
        end
        WB: begin
          if (wb_ack) begin
            state    <= FILL;
            wb_req   <= 1'b0;
            fill_req <= 1'b1;
          end
        end
        FILL: begin
          if (fill_ack) begin
            state        <= MISS_UPD;
            fill_req     <= 1'b0;
            plru_load    <= 1'b1;
            plru_tag_hit <= S_ASSOC'(1) << victim;
            resp_valid   <= 1'b1;
            resp_way     <= victim;
          end
        end
        MISS_UPD: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          wb_req    <= 1'b0;
          fill_req  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLRU_VICTIM_STATS_EN
  // Saturating event counters for hits, completed misses and completed writebacks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_wbs    <= '0;
    end else begin
      if (state == HIT_UPD && stat_hits != '1)           stat_hits   <= stat_hits + 32'd1;
      if (state == MISS_UPD && stat_misses != '1)        stat_misses <= stat_misses + 32'd1;
      if (state == WB && wb_ack && stat_wbs != '1)       stat_wbs    <= stat_wbs + 32'd1;
    end
  end
`endif

  // A hit must name exactly one way.
  a_hit_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    (req_valid && req_ready && req_hit) |-> $onehot(req_hit_way));

  // Array read and load are mutually exclusive.
  a_rd_ld_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(plru_read && plru_load));

endmodule

// File: tb/tb_plru_victim_ctrl.sv
// tb_plru_victim_ctrl
//   Table-driven and randomized checks of plru_victim_ctrl against a
//   behavioural model of victim choice, handshake lengths and latency.
module tb_plru_victim_ctrl;

  localparam int S_INDEX = 3;
  localparam int S_ASSOC = 8;
  localparam int S_WIDTH = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic [S_INDEX-1:0] req_index;
  logic               req_hit;
  logic [S_ASSOC-1:0] req_hit_way;
  logic [S_ASSOC-1:0] set_valid;
  logic [S_ASSOC-1:0] set_dirty;
  logic               plru_read;
  logic               plru_load;
  logic [S_INDEX-1:0] plru_index;
  logic [S_ASSOC-1:0] plru_tag_hit;
  logic [S_WIDTH-1:0] plru_way;
  logic               plru_valid;
  logic               wb_req;
  logic               wb_ack;
  logic               fill_req;
  logic               fill_ack;
  logic               resp_valid;
  logic [S_WIDTH-1:0] resp_way;

  int n_checks = 0;
  int n_fail   = 0;

  plru_victim_ctrl #(.S_INDEX(S_INDEX), .S_ASSOC(S_ASSOC), .S_WIDTH(S_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .req_hit(req_hit), .req_hit_way(req_hit_way),
    .set_valid(set_valid), .set_dirty(set_dirty),
    .plru_read(plru_read), .plru_load(plru_load), .plru_index(plru_index),
    .plru_tag_hit(plru_tag_hit), .plru_way(plru_way), .plru_valid(plru_valid),
    .wb_req(wb_req), .wb_ack(wb_ack), .fill_req(fill_req), .fill_ack(fill_ack),
    .resp_valid(resp_valid), .resp_way(resp_way)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               hit;
    logic [S_INDEX-1:0] index;
    logic [S_ASSOC-1:0] hit_way;
    logic [S_ASSOC-1:0] valid;
    logic [S_ASSOC-1:0] dirty;
    logic [S_WIDTH-1:0] pway;
    logic               pvalid;
    int                 wd;       // WB cycle on which wb_ack is raised
    int                 fd;       // FILL cycle on which fill_ack is raised
    int                 exp_way;
    bit                 exp_wb;
  } vec_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Spec rule: lowest invalid way, else the PLRU way when valid, else way 0.
  function automatic int model_victim(input logic [S_ASSOC-1:0] valid,
                                      input logic [S_WIDTH-1:0] pway, input logic pvalid);
    for (int i = 0; i < S_ASSOC; i++) if (!valid[i]) return i;
    return pvalid ? int'(pway) : 0;
  endfunction

  // One full transaction; starts in the IDLE cycle and ends on the resp_valid cycle.
  task automatic run_req(input vec_t v, input bit noise);
    int cyc, rd_cnt, wb_cnt, fill_cnt, idx_err, overlap, lat;
    int exp_lat;
    logic [S_WIDTH-1:0] got_way;
    logic [S_ASSOC-1:0] got_tag, exp_tag;
    logic got_load;
    rd_cnt = 0; wb_cnt = 0; fill_cnt = 0; idx_err = 0; overlap = 0; lat = -1;
    got_way = '0; got_tag = '0; got_load = 1'b0;
    @(negedge clk);
    check("ready_idle", req_ready, 1'b1);
    check("resp_low_idle", resp_valid, 1'b0);
    req_valid   = 1'b1;
    req_index   = v.index;
    req_hit     = v.hit;
    req_hit_way = v.hit_way;
    set_valid   = v.valid;
    set_dirty   = v.dirty;
    plru_way    = v.pway;
    plru_valid  = v.pvalid;
    for (cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        // Scramble request inputs after accept: the DUT must use its latched copies.
        req_valid   = 1'b0;
        req_index   = S_INDEX'($urandom);
        req_hit_way = S_ASSOC'($urandom);
        set_valid   = S_ASSOC'($urandom);
        set_dirty   = S_ASSOC'($urandom);
      end
      if (plru_read) rd_cnt++;
      if (plru_read && plru_load) overlap++;
      if (plru_index !== v.index) idx_err++;
      if (wb_req) begin
        wb_cnt++;
        wb_ack = (wb_cnt == v.wd);
      end else begin
        wb_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (fill_req) begin
        fill_cnt++;
        fill_ack = (fill_cnt == v.fd);
      end else begin
        fill_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (resp_valid) begin
        lat      = cyc;
        got_way  = resp_way;
        got_tag  = plru_tag_hit;
        got_load = plru_load;
        break;
      end
    end
    wb_ack   = 1'b0;
    fill_ack = 1'b0;
    exp_lat = v.hit ? 1 : 3 + (v.exp_wb ? v.wd : 0) + v.fd;
    exp_tag = v.hit ? v.hit_way : (S_ASSOC'(1) << v.exp_way);
    check("latency", lat, exp_lat);
    check("resp_way", got_way, v.exp_way);
    check("tag_hit", got_tag, exp_tag);
    check("load_at_resp", got_load, 1'b1);
    check("read_cycles", rd_cnt, v.hit ? 0 : 1);
    check("wb_cycles", wb_cnt, v.exp_wb ? v.wd : 0);
    check("fill_cycles", fill_cnt, v.hit ? 0 : v.fd);
    check("index_stable", idx_err, 0);
    check("read_load_overlap", overlap, 0);
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_index = '0; req_hit = 1'b0; req_hit_way = '0;
    set_valid = '0; set_dirty = '0; plru_way = '0; plru_valid = 1'b0;
    wb_ack = 1'b0; fill_ack = 1'b0;

    //        hit   idx    hit_way      valid        dirty        pway  pv    wd fd way wb
    tbl[0] = '{1'b1, 3'd5, 8'b0001_0000, 8'hFF,       8'h00,       3'd0, 1'b1, 1, 1, 4, 1'b0};
    tbl[1] = '{1'b0, 3'd1, 8'h00,        8'hFF,       8'h00,       3'd3, 1'b1, 1, 2, 3, 1'b0};
    tbl[2] = '{1'b0, 3'd2, 8'h00,        8'b1111_1011, 8'h04,      3'd6, 1'b1, 1, 1, 2, 1'b0};
    tbl[3] = '{1'b0, 3'd7, 8'h00,        8'hFF,       8'h40,       3'd6, 1'b1, 3, 1, 6, 1'b1};
    tbl[4] = '{1'b0, 3'd3, 8'h00,        8'hFF,       8'h01,       3'd5, 1'b0, 1, 3, 0, 1'b1};
    tbl[5] = '{1'b1, 3'd0, 8'h80,        8'h00,       8'hFF,       3'd2, 1'b1, 1, 1, 7, 1'b0};
    tbl[6] = '{1'b0, 3'd4, 8'h00,        8'h00,       8'hFF,       3'd7, 1'b1, 1, 1, 0, 1'b0};
    tbl[7] = '{1'b0, 3'd6, 8'h00,        8'b0111_1111, 8'h80,      3'd1, 1'b1, 2, 1, 7, 1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_plru_read", plru_read, 1'b0);
    check("rst_plru_load", plru_load, 1'b0);
    check("rst_wb_req", wb_req, 1'b0);
    check("rst_fill_req", fill_req, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_way", resp_way, 0);
    check("rst_plru_index", plru_index, 0);
    check("rst_plru_tag_hit", plru_tag_hit, 0);

    // Directed table, back to back.
    for (int i = 0; i < 8; i++) run_req(tbl[i], 1'b0);

    // Reset pulsed while in FILL: fill_req must drop at once and no response may appear.
    begin
      int seen;
      seen = 0;
      @(negedge clk);
      req_valid = 1'b1; req_index = 3'd6; req_hit = 1'b0; req_hit_way = '0;
      set_valid = 8'hFF; set_dirty = 8'h00; plru_way = 3'd1; plru_valid = 1'b1;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        req_valid = 1'b0;
        if (fill_req) seen = 1;
      end
      check("midfill_reached", seen, 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midfill_fill_drop", fill_req, 1'b0);
      check("midfill_no_resp", resp_valid, 1'b0);
      check("midfill_ready", req_ready, 1'b1);
      @(negedge clk);
      check("midfill_no_resp_hold", resp_valid, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check("midfill_no_resp_after", resp_valid, 1'b0);
      run_req(tbl[0], 1'b0);
      run_req(tbl[3], 1'b0);
    end

    // Randomized transactions with spurious acks outside their phase.
    for (int n = 0; n < 40; n++) begin
      rv.hit     = ($urandom_range(0, 2) == 0);
      rv.index   = S_INDEX'($urandom);
      rv.hit_way = S_ASSOC'(1) << $urandom_range(0, S_ASSOC - 1);
      rv.valid   = $urandom_range(0, 1) ? 8'hFF : S_ASSOC'($urandom);
      rv.dirty   = S_ASSOC'($urandom);
      rv.pway    = S_WIDTH'($urandom);
      rv.pvalid  = ($urandom_range(0, 3) != 0);
      rv.wd      = $urandom_range(1, 4);
      rv.fd      = $urandom_range(1, 4);
      if (rv.hit) begin
        for (int w = 0; w < S_ASSOC; w++) if (rv.hit_way[w]) rv.exp_way = w;
        rv.exp_wb = 1'b0;
      end else begin
        rv.exp_way = model_victim(rv.valid, rv.pway, rv.pvalid);
        rv.exp_wb  = rv.valid[rv.exp_way] && rv.dirty[rv.exp_way];
      end
      run_req(rv, 1'b1);
    end

    @(negedge clk);
    check("final_resp_low", resp_valid, 1'b0);
    check("final_ready", req_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
